// File: rtl/vc_burst_arbiter_pkg.sv
// Shared definitions for the virtual-channel burst arbiter.
// Holds FSM state encodings, default word geometry and the source slicing helper.
package vc_burst_arbiter_pkg;

    localparam int DEF_DATA_W   = 10;
    localparam int DEF_DEST_BIT = 9;

    // One-hot FSM encoding, matching the transaction-layer FSM style.
    localparam logic [1:0] ST_IDLE  = 2'b01;
    localparam logic [1:0] ST_GRANT = 2'b10;

    // Source idx occupies src_data[src_lsb(idx, w) +: w].
    function automatic int src_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/vc_burst_arbiter_pick.sv
// rr_pick4: combinational round-robin picker over 4 requesters.
// Ports: elig/excl request and exclusion masks, last previous winner; pick id and found flag.
module rr_pick4
    import vc_burst_arbiter_pkg::*;
(
    input  logic [3:0] elig,
    input  logic [1:0] last,
    input  logic [3:0] excl,
    output logic [1:0] pick,
    output logic       found
);

    logic [3:0] cand;

    // Scan from the farthest offset down so the nearest candidate wins.
    always_comb begin
        cand  = elig & ~excl;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (cand[last + 2'(k)]) begin
                pick  = last + 2'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_burst_arbiter.sv
// Moves words from 4 FWFT source FIFOs to 2 destination FIFOs, round-robin with a burst limit.
// Ports: src_empty/src_data/src_pop source side, dst_almost_full/dst_push/dst_data sink side, status outputs.
module vc_burst_arbiter
    import vc_burst_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEST_BIT = DEF_DEST_BIT,
    parameter int NUM_SRC  = 4,
    parameter int BURST    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_SRC-1:0]          src_empty,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic [NUM_SRC-1:0]          src_pop,
    input  logic [1:0]                  dst_almost_full,
    output logic [1:0]                  dst_push,
    output logic [DATA_W-1:0]           dst_data,
    output logic [1:0]                  grant_id,
    output logic                        busy,
    output logic [7:0]                  xfer_count
);

    logic [1:0]         state_q, state_d;
    logic [1:0]         grant_id_q, grant_id_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [3:0]         burst_cnt_q, burst_cnt_d;
    logic [1:0]         dst_push_q, dst_push_d;
    logic [DATA_W-1:0]  dst_data_q, dst_data_d;
    logic [7:0]         xfer_count_q, xfer_count_d;

    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] own_mask;
    logic [NUM_SRC-1:0] excl;
    logic [1:0]         pick;
    logic               found;
    logic               in_grant;
    logic               keep;
    logic               pop_v;
    logic [1:0]         pop_id;
    logic [DATA_W-1:0]  pop_word;

    // A source is eligible only if its head word's destination can accept it.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = enable && !src_empty[i]
                   && !dst_almost_full[src_data[src_lsb(i, DATA_W) + DEST_BIT]];
        end
    end

    assign in_grant = (state_q == ST_GRANT);
    assign own_mask = {{(NUM_SRC-1){1'b0}}, 1'b1} << grant_id_q;
    assign keep     = in_grant && elig[grant_id_q]
                   && (burst_cnt_q < 4'(BURST));

    // Owner is excluded on re-arbitration unless nobody else is eligible.
    always_comb begin
        excl = '0;
        if (in_grant && ((elig & ~own_mask) != '0)) begin
            excl = own_mask;
        end
    end

    rr_pick4 u_pick (
        .elig  (elig),
        .last  (last_grant_q),
        .excl  (excl),
        .pick  (pick),
        .found (found)
    );

    assign pop_v    = !reset && (keep || found);
    assign pop_id   = keep ? grant_id_q : pick;
    assign pop_word = src_data[src_lsb(int'(pop_id), DATA_W) +: DATA_W];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= 2'd0;
            last_grant_q <= 2'd3;
            burst_cnt_q  <= 4'd0;
            dst_push_q   <= 2'b00;
            dst_data_q   <= '0;
            xfer_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            dst_push_q   <= dst_push_d;
            dst_data_q   <= dst_data_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        if (keep) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end else if (found) begin
            state_d      = ST_GRANT;
            grant_id_d   = pick;
            last_grant_d = pick;
            burst_cnt_d  = 4'd1;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Push pipeline: one register stage between pop and push.
    always_comb begin
        dst_push_d   = 2'b00;
        dst_data_d   = dst_data_q;
        xfer_count_d = xfer_count_q;
        if (pop_v) begin
            dst_push_d   = pop_word[DEST_BIT] ? 2'b10 : 2'b01;
            dst_data_d   = pop_word;
            xfer_count_d = xfer_count_q + 8'd1;
        end
    end

    // Outputs.
    always_comb begin
        src_pop = '0;
        if (pop_v) begin
            src_pop[pop_id] = 1'b1;
        end
    end

    assign dst_push   = dst_push_q;
    assign dst_data   = dst_data_q;
    assign grant_id   = grant_id_q;
    assign xfer_count = xfer_count_q;
    assign busy       = in_grant || (dst_push_q != 2'b00);

endmodule

// File: tb/tb_vc_burst_arbiter.sv
// Self-checking bench for vc_burst_arbiter.
// Drives FWFT source queues and checks pops, pushes and status against a reference model.
module tb_vc_burst_arbiter;

    typedef struct {
        logic [9:0] word;
        logic       dest;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  src_empty;
    logic [39:0] src_data;
    logic [3:0]  src_pop;
    logic [1:0]  dst_almost_full;
    logic [1:0]  dst_push;
    logic [9:0]  dst_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  xfer_count;

    vc_burst_arbiter #(
        .DATA_W   (10),
        .DEST_BIT (9),
        .NUM_SRC  (4),
        .BURST    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .src_empty       (src_empty),
        .src_data        (src_data),
        .src_pop         (src_pop),
        .dst_almost_full (dst_almost_full),
        .dst_push        (dst_push),
        .dst_data        (dst_data),
        .grant_id        (grant_id),
        .busy            (busy),
        .xfer_count      (xfer_count)
    );

    always #5 clk = ~clk;

    logic [9:0] srcq[4][$];
    sb_t        sb[$];
    int         plog[$];

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_push   = 0;

    bit         rst_v = 1'b0;
    bit         en_v  = 1'b0;
    logic [1:0] af_v  = 2'b00;
    bit         rand_af = 1'b0;

    bit         m_grant;
    int         m_gid;
    int         m_last;
    int         m_cnt;
    logic [7:0] m_xfer;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [3:0] el;
        logic [3:0] other;
        logic [3:0] exp_pop;
        int         pk;
        bit         keep;
        bit         had;
        sb_t        e;
        @(negedge clk);
        had = (sb.size() > 0);
        if (had) begin
            e = sb.pop_front();
            check("dst_push", 32'(dst_push), e.dest ? 32'd2 : 32'd1);
            check("dst_data", 32'(dst_data), 32'(e.word));
        end else begin
            check("no_push", 32'(dst_push), 32'd0);
        end
        if (dst_push != 2'b00) n_push++;
        check("xfer_count", 32'(xfer_count), 32'(m_xfer));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("busy", 32'(busy), 32'(m_grant || had));

        if (rand_af) af_v = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
        reset           = rst_v;
        enable          = en_v;
        dst_almost_full = af_v;
        for (int i = 0; i < 4; i++) begin
            src_empty[i] = (srcq[i].size() == 0);
            src_data[i*10 +: 10] = src_empty[i] ? 10'($urandom) : srcq[i][0];
        end
        #1;
        exp_pop = 4'b0000;
        pk      = -1;
        keep    = 1'b0;
        if (!rst_v) begin
            for (int i = 0; i < 4; i++) begin
                el[i] = en_v && !src_empty[i] && !af_v[src_data[i*10+9]];
            end
            keep = m_grant && el[m_gid] && (m_cnt < 4);
            if (keep) begin
                pk = m_gid;
            end else begin
                other = el;
                other[m_gid] = 1'b0;
                for (int off = 1; off <= 4 && pk < 0; off++) begin
                    int c;
                    c = (m_last + off) % 4;
                    if (el[c] && !(m_grant && c == m_gid && other != 4'b0000))
                        pk = c;
                end
            end
        end
        if (pk >= 0) exp_pop[pk] = 1'b1;
        check("src_pop", 32'(src_pop), 32'(exp_pop));

        if (rst_v) begin
            m_grant = 1'b0;
            m_gid   = 0;
            m_last  = 3;
            m_cnt   = 0;
            m_xfer  = 8'd0;
            sb.delete();
        end else if (pk >= 0) begin
            e.word = srcq[pk].pop_front();
            e.dest = e.word[9];
            sb.push_back(e);
            plog.push_back(pk);
            m_xfer++;
            if (keep) begin
                m_cnt++;
            end else begin
                m_cnt   = 1;
                m_grant = 1'b1;
                m_gid   = pk;
                m_last  = pk;
            end
        end else begin
            m_grant = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        step();
        step();
        rst_v = 1'b0;
        plog.delete();
    endtask

    task automatic load(input int s, input int n, input int dest);
        logic [9:0] w;
        for (int k = 0; k < n; k++) begin
            w = 10'($urandom);
            if (dest >= 0) w[9] = 1'(dest);
            srcq[s].push_back(w);
        end
    endtask

    // Compare pop order with a nibble-per-entry sequence, first entry leftmost.
    task automatic check_log(input string tag, input logic [127:0] seq,
                             input int n);
        check({tag, "_len"}, 32'(plog.size()), 32'(n));
        for (int k = 0; k < n && k < plog.size(); k++) begin
            check(tag, 32'(plog[k]), 32'(seq[4*(n-1-k) +: 4]));
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int guard;
        reset           = 1'b1;
        enable          = 1'b0;
        src_empty       = 4'hf;
        src_data        = '0;
        dst_almost_full = 2'b00;
        repeat (2) @(posedge clk);
        m_grant = 1'b0;
        m_gid   = 0;
        m_last  = 3;
        m_cnt   = 0;
        m_xfer  = 8'd0;
        do_reset();

        // Single source, three words to D0.
        en_v = 1'b1;
        load(0, 3, 0);
        repeat (5) step();
        post_edge();
        check("s1_xfer", 32'(xfer_count), 32'd3);
        check("s1_busy", 32'(busy), 32'd0);
        check_log("s1_order", 128'h000, 3);

        // Burst limit and rotation.
        do_reset();
        for (int s = 0; s < 4; s++) load(s, 6, -1);
        repeat (24) step();
        check_log("rot_order", 128'h0000_1111_2222_3333_0011_2233, 24);
        repeat (2) step();
        post_edge();
        check("rot_xfer", 32'(xfer_count), 32'd24);

        // Destination backpressure.
        do_reset();
        af_v = 2'b10;
        load(1, 1, 1);
        load(2, 1, 0);
        repeat (3) step();
        af_v = 2'b00;
        repeat (3) step();
        check_log("bp_order", 128'h21, 2);

        // Enable drop mid-burst.
        do_reset();
        load(0, 4, -1);
        load(1, 2, -1);
        repeat (2) step();
        en_v = 1'b0;
        repeat (3) step();
        post_edge();
        check("en_xfer", 32'(xfer_count), 32'd2);
        check("en_busy", 32'(busy), 32'd0);
        en_v = 1'b1;
        repeat (8) step();
        check_log("en_order", 128'h00_1100, 6);

        // Reset during an in-flight push.
        do_reset();
        load(0, 3, -1);
        load(1, 3, -1);
        step();
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        post_edge();
        check("rst_push", 32'(dst_push), 32'd0);
        check("rst_xfer", 32'(xfer_count), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        plog.delete();
        repeat (8) step();
        check_log("rst_order", 128'h00111, 5);

        // Counter wrap over 256 words with random backpressure.
        do_reset();
        for (int s = 0; s < 4; s++) load(s, 64, -1);
        n_push  = 0;
        rand_af = 1'b1;
        guard   = 0;
        while ((srcq[0].size() + srcq[1].size() + srcq[2].size()
                + srcq[3].size() + sb.size()) != 0 && guard < 4000) begin
            step();
            guard++;
        end
        rand_af = 1'b0;
        af_v    = 2'b00;
        check("wrap_timeout", 32'(guard < 4000), 32'd1);
        step();
        post_edge();
        check("wrap_xfer", 32'(xfer_count), 32'd0);
        check("wrap_pushes", 32'(n_push), 32'd256);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
